// File: rtl/block_serial_cla_if.sv
// Operand/result bundle for block_serial_cla; the optional sub strobe exists only with CLA_SUB_EN.
interface block_serial_cla_if #(parameter int WIDTH = 16);
  logic             start;
  logic             cin;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
`ifdef CLA_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic             ovf;

`ifdef CLA_SUB_EN
  modport master (output start, cin, x, y, sub, input busy, done, z, cout, ovf);
  modport slave  (input start, cin, x, y, sub, output busy, done, z, cout, ovf);
`else
  modport master (output start, cin, x, y, input busy, done, z, cout, ovf);
  modport slave  (input start, cin, x, y, output busy, done, z, cout, ovf);
`endif
endinterface

// File: rtl/block_serial_cla.sv
// Multi-cycle adder: one GROUP-bit carry-lookahead slice per cycle, WIDTH/GROUP cycles per sum.
// Optional macro CLA_SUB_EN adds a sub input selecting x - y - cin.
module cla_group #(parameter int GROUP = 4) (
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  input  logic             i_c,
  output logic [GROUP-1:0] o_s,
  output logic             o_co,
  output logic             o_cm
);
  logic [GROUP-1:0] w_g, w_p;
  logic [GROUP:0]   w_c;
  logic             w_t;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is a flat sum of products of g/p and the group carry-in.
  always_comb begin
    w_c    = '0;
    w_t    = 1'b0;
    w_c[0] = i_c;
    for (int i = 1; i <= GROUP; i++) begin
      for (int j = 0; j < i; j++) begin
        w_t = w_g[j];
        for (int k = j + 1; k < i; k++) w_t = w_t & w_p[k];
        w_c[i] = w_c[i] | w_t;
      end
      w_t = i_c;
      for (int k = 0; k < i; k++) w_t = w_t & w_p[k];
      w_c[i] = w_c[i] | w_t;
    end
  end

  assign o_s  = w_p ^ w_c[GROUP-1:0];
  assign o_co = w_c[GROUP];
  assign o_cm = w_c[GROUP-1];
endmodule

module block_serial_cla #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input logic               clk,
  input logic               res,
  block_serial_cla_if.slave bus
);
  localparam int NG = WIDTH / GROUP;
  localparam int IW = (NG > 1) ? $clog2(NG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum, r_z;
  logic             r_c, r_cout, r_ovf;
  logic [IW-1:0]    r_idx;
  logic [GROUP-1:0] w_s;
  logic             w_co, w_cm, w_last;
  logic [WIDTH-1:0] w_sum, w_bin;
  logic             w_cin;

`ifdef CLA_SUB_EN
  assign w_bin = bus.sub ? ~bus.y : bus.y;
  assign w_cin = bus.cin ^ bus.sub;
`else
  assign w_bin = bus.y;
  assign w_cin = bus.cin;
`endif

  // Operands shift right each cycle so the active group is always bits [GROUP-1:0].
  cla_group #(.GROUP(GROUP)) u_grp (
    .i_a (r_a[GROUP-1:0]),
    .i_b (r_b[GROUP-1:0]),
    .i_c (r_c),
    .o_s (w_s),
    .o_co(w_co),
    .o_cm(w_cm)
  );

  assign w_last = (r_idx == IW'(NG - 1));
  assign w_sum  = (r_sum >> GROUP) | (WIDTH'(w_s) << (WIDTH - GROUP));

  always_ff @(posedge clk) begin
    if (res) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_c    <= 1'b0;
      r_idx  <= '0;
      r_z    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_a   <= bus.x;
          r_b   <= w_bin;
          r_c   <= w_cin;
          r_idx <= '0;
        end
        RUN: begin
          r_a   <= r_a >> GROUP;
          r_b   <= r_b >> GROUP;
          r_sum <= w_sum;
          r_c   <= w_co;
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_z    <= w_sum;
            r_cout <= w_co;
            r_ovf  <= w_co ^ w_cm;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.z    = r_z;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_block_serial_cla.sv
// Scoreboard bench for block_serial_cla: a 16/4 instance under a cycle model, plus a 4/4 instance.
module tb_block_serial_cla;
  localparam int NG = 4;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  block_serial_cla_if #(.WIDTH(16)) bus ();
  block_serial_cla_if #(.WIDTH(4))  b4 ();

  block_serial_cla #(.WIDTH(16), .GROUP(4)) dut (.clk(clk), .res(res), .bus(bus));
  block_serial_cla #(.WIDTH(4),  .GROUP(4)) dut4 (.clk(clk), .res(res), .bus(b4));

  typedef struct packed {logic [15:0] z; logic co; logic ov;} exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_fail = 0;
  int          m_st = 0, m_cnt = 0;
  logic [15:0] m_z = '0;
  logic        m_co = 1'b0, m_ov = 1'b0;
  logic        chk_en = 1'b0, streaming = 1'b0;
  int          cyc = 0, last_done = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
    exp_t        e;
    logic [15:0] b;
    logic        ci;
    logic [16:0] t;
    b    = s ? ~y : y;
    ci   = s ? ~c : c;
    t    = {1'b0, x} + {1'b0, b} + {16'd0, ci};
    e.z  = t[15:0];
    e.co = t[16];
    e.ov = (x[15] == b[15]) && (t[15] != x[15]);
    return e;
  endfunction

  function automatic logic cur_sub();
`ifdef CLA_SUB_EN
    return bus.sub;
`else
    return 1'b0;
`endif
  endfunction

  // Cycle model: 0 idle, 1 run, 2 done; expectations are pushed on acceptance.
  always @(posedge clk) begin
    exp_t e;
    if (res) begin
      m_st = 0; m_cnt = 0; q.delete();
      m_z = '0; m_co = 1'b0; m_ov = 1'b0;
    end else begin
      case (m_st)
        0: if (bus.start) begin
          q.push_back(model(bus.x, bus.y, bus.cin, cur_sub()));
          m_st = 1; m_cnt = 0;
        end
        1: begin
          m_cnt++;
          if (m_cnt == NG) begin
            e = q.pop_front();
            m_z = e.z; m_co = e.co; m_ov = e.ov;
            m_st = 2;
          end
        end
        default: m_st = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      chk("busy", bus.busy, m_st == 1);
      chk("done", bus.done, m_st == 2);
      chk("z",    bus.z,    m_z);
      chk("cout", bus.cout, m_co);
      chk("ovf",  bus.ovf,  m_ov);
      if (bus.done) begin
        if (streaming && last_done >= 0) chk("stream_gap", cyc - last_done, 6);
        last_done = cyc;
      end
    end
  end

  task automatic set_sub(input logic s);
`ifdef CLA_SUB_EN
    bus.sub = s;
`endif
  endtask

  // Accepts one op, then scrambles inputs and pokes start while the op is busy/done.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
    @(negedge clk);
    bus.start = 1'b1; bus.x = x; bus.y = y; bus.cin = c; set_sub(s);
    for (int i = 1; i <= NG; i++) begin
      @(negedge clk);
      bus.start = 1'(($urandom & 1));
      bus.x = 16'($urandom); bus.y = 16'($urandom); bus.cin = 1'($urandom & 1);
      set_sub(1'($urandom & 1));
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    int n;
    res = 1'b1;
    bus.start = 1'b1; bus.x = 16'hAAAA; bus.y = 16'h5555; bus.cin = 1'b1; set_sub(1'b0);
    b4.start = 1'b0; b4.x = '0; b4.y = '0; b4.cin = 1'b0;
`ifdef CLA_SUB_EN
    b4.sub = 1'b0;
`endif
    @(posedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_z", bus.z, 0);
    res = 1'b0; bus.start = 1'b0;

    run_op(16'h0001, 16'h0002, 1'b0, 1'b0);
    chk("r027_z", bus.z, 16'h0003); chk("r027_co", bus.cout, 0); chk("r027_ov", bus.ovf, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    chk("r028a_z", bus.z, 16'h0000); chk("r028a_co", bus.cout, 1); chk("r028a_ov", bus.ovf, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("r028b_z", bus.z, 16'h8000); chk("r028b_co", bus.cout, 0); chk("r028b_ov", bus.ovf, 1);
`ifdef CLA_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    chk("r031a_z", bus.z, 16'hFFFE); chk("r031a_co", bus.cout, 0); chk("r031a_ov", bus.ovf, 0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    chk("r031b_z", bus.z, 16'h7FFF); chk("r031b_co", bus.cout, 1); chk("r031b_ov", bus.ovf, 1);
`endif
    for (int i = 0; i < 16; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom & 1), 1'($urandom & 1));

    // Continuous start with operands changing every cycle.
    last_done = -1; streaming = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus.x = 16'($urandom); bus.y = 16'($urandom); bus.cin = 1'($urandom & 1);
      set_sub(1'($urandom & 1));
      @(negedge clk);
    end
    bus.start = 1'b0; streaming = 1'b0;
    repeat (8) @(negedge clk);

    // Abort in the second RUN cycle.
    bus.start = 1'b1; bus.x = 16'h4321; bus.y = 16'h1111; bus.cin = 1'b0; set_sub(1'b0);
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); res = 1'b1;
    @(negedge clk); res = 1'b0;
    chk("r030_busy", bus.busy, 0); chk("r030_done", bus.done, 0);
    chk("r030_z", bus.z, 0); chk("r030_co", bus.cout, 0); chk("r030_ov", bus.ovf, 0);
    repeat (6) begin
      @(negedge clk);
      chk("r030_nodone", bus.done, 0);
    end
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    chk("r030_z2", bus.z, 16'h2345);

    // Single-group instance.
    @(negedge clk);
    b4.start = 1'b1; b4.x = 4'h9; b4.y = 4'h8; b4.cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b4.start = 1'b0; b4.x = 4'h0; b4.y = 4'h0; b4.cin = 1'b0;
    n = 0;
    while (n < 8 && !b4.done) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk("r032_lat", n, 1);
    chk("r032_done", b4.done, 1);
    chk("r032_z", b4.z, 4'h2); chk("r032_co", b4.cout, 1); chk("r032_ov", b4.ovf, 1);
    @(negedge clk);
    chk("r032_pulse", b4.done, 0);
    chk("r032_hold", b4.z, 4'h2);

    repeat (4) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
